des_round_engine: RTL and testbench

Iterative 16-round DES Feistel core, directly upstream of the final-permutation stage. It accepts the initially-permuted block L0‖R0 and a 64-bit key, and runs one round per clock with an on-the-fly key schedule. It delivers the pre-output R16‖L16, with the halves swapped, plus a one-cycle completion pulse that drives the final-permutation start input. Both encryption and decryption are supported; the direction is selected per block.

---
 rtl/des_pkg.sv | 73 +++++++
 rtl/des_round_engine_sbox.sv | 14 +
 rtl/des_round_engine.sv | 120 ++++++++++++
 tb/tb_des_round_engine.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared DES constants: permutation tables, shift schedule, S-boxes, FSM state
// and the bit-gathering helpers used by the round engine.
package des_pkg;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ROUND = 1'b1} state_t;

  // All tables hold 1-based DES bit numbers; output bit i takes input bit TABLE[i]-1.
  localparam int PC1 [0:55] = '{
    57,49,41,33,25,17, 9, 1,58,50,42,34,26,18,10, 2,59,51,43,35,27,19,11, 3,60,52,44,36,
    63,55,47,39,31,23,15, 7,62,54,46,38,30,22,14, 6,61,53,45,37,29,21,13, 5,28,20,12, 4};
  localparam int PC2 [0:47] = '{
    14,17,11,24, 1, 5, 3,28,15, 6,21,10,23,19,12, 4,26, 8,16, 7,27,20,13, 2,
    41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  localparam int E [0:47] = '{
    32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9,10,11,12,13,12,13,14,15,16,17,
    16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32, 1};
  localparam int P [0:31] = '{
    16, 7,20,21,29,12,28,17, 1,15,23,26, 5,18,31,10,
     2, 8,24,14,32,27, 3, 9,19,13,30, 6,22,11, 4,25};
  localparam int SHIFTS [1:16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  // Indexed by {row, col}, i.e. row*16 + col.
  localparam logic [3:0] SBOX [0:7][0:63] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,  0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,  15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,  3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,  13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,  13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,  1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,  13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,  3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,  14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,  11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,  13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,  6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,  1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,  2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  function automatic logic [0:55] pc1(input logic [0:63] k);
    logic [0:55] o;
    for (int i = 0; i < 56; i++) o[6'(i)] = k[6'(PC1[i] - 1)];
    return o;
  endfunction

  function automatic logic [0:47] pc2(input logic [0:55] cd);
    logic [0:47] o;
    for (int i = 0; i < 48; i++) o[6'(i)] = cd[6'(PC2[i] - 1)];
    return o;
  endfunction

  function automatic logic [0:47] expand(input logic [0:31] r);
    logic [0:47] o;
    for (int i = 0; i < 48; i++) o[6'(i)] = r[5'(E[i] - 1)];
    return o;
  endfunction

  function automatic logic [0:31] perm_p(input logic [0:31] s);
    logic [0:31] o;
    for (int i = 0; i < 32; i++) o[5'(i)] = s[5'(P[i] - 1)];
    return o;
  endfunction

  function automatic logic [0:27] rotl(input logic [0:27] h, input logic two);
    return two ? {h[2:27], h[0:1]} : {h[1:27], h[0]};
  endfunction

  function automatic logic [0:27] rotr(input logic [0:27] h, input logic two);
    return two ? {h[26:27], h[0:25]} : {h[27], h[0:26]};
  endfunction

endpackage

// File: rtl/des_round_engine_sbox.sv
// All eight DES S-boxes side by side: 48-bit E(R)^K in, 32-bit result out.
module des_sbox
  import des_pkg::*;
(
  input  logic [0:47] x,
  output logic [0:31] y
);
  for (genvar j = 0; j < 8; j++) begin : g_box
    logic [5:0] b;
    assign b = x[6*j +: 6];
    // Row from the outer bits, column from the inner four.
    assign y[4*j +: 4] = SBOX[j][{b[5], b[0], b[4:1]}];
  end
endmodule

// File: rtl/des_round_engine.sv
// Iterative DES Feistel core: one round per clock, key schedule rotated on the fly,
// emits R16||L16 with a one-cycle done pulse for the final-permutation stage.
module des_round_engine
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        decrypt,
  input  logic [0:63] block_in,
  input  logic [0:63] key,
  output logic        busy,
  output logic        done,
  output logic [0:63] preout
);
  state_t      state_q, state_d;
  logic [3:0]  rnd_q, rnd_d;
  logic [0:31] l_q, l_d, r_q, r_d;
  logic [0:55] cd_q, cd_d;
  logic        mode_q, mode_d;
  logic        done_q, done_d;
  logic [0:63] preout_q, preout_d;

  logic [4:0]  sidx;
  logic        sh2;
  logic [0:27] c_rot, d_rot;
  logic [0:55] cd_rnd;
  logic [0:47] subkey, sbox_in;
  logic [0:31] sbox_out, f_out;

  // Decrypt walks the schedule backwards: no rotation in round 1, then right by s[17-rnd].
  always_comb begin
    sidx = mode_q ? 5'd17 - {1'b0, rnd_q} : {1'b0, rnd_q} + 5'd1;
    sh2  = 1'b0;
    for (int n = 1; n <= 16; n++)
      if (n == int'(sidx)) sh2 = (SHIFTS[n] == 2);
    c_rot = cd_q[0:27];
    d_rot = cd_q[28:55];
    if (!mode_q) begin
      c_rot = rotl(cd_q[0:27], sh2);
      d_rot = rotl(cd_q[28:55], sh2);
    end else if (rnd_q != 4'd0) begin
      c_rot = rotr(cd_q[0:27], sh2);
      d_rot = rotr(cd_q[28:55], sh2);
    end
    cd_rnd = {c_rot, d_rot};
    subkey = pc2(cd_rnd);
  end

  assign sbox_in = expand(r_q) ^ subkey;

  des_sbox u_sbox (
    .x (sbox_in),
    .y (sbox_out)
  );

  assign f_out = perm_p(sbox_out);

  always_comb begin
    state_d  = state_q;
    rnd_d    = rnd_q;
    l_d      = l_q;
    r_d      = r_q;
    cd_d     = cd_q;
    mode_d   = mode_q;
    preout_d = preout_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ROUND;
          l_d     = block_in[0:31];
          r_d     = block_in[32:63];
          cd_d    = pc1(key);
          mode_d  = decrypt;
          rnd_d   = 4'd0;
        end
      end
      ST_ROUND: begin
        l_d   = r_q;
        r_d   = l_q ^ f_out;
        cd_d  = cd_rnd;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == 4'd15) begin
          state_d  = ST_IDLE;
          preout_d = {l_q ^ f_out, r_q};
          done_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rnd_q    <= 4'd0;
      l_q      <= '0;
      r_q      <= '0;
      cd_q     <= '0;
      mode_q   <= 1'b0;
      done_q   <= 1'b0;
      preout_q <= '0;
    end else begin
      state_q  <= state_d;
      rnd_q    <= rnd_d;
      l_q      <= l_d;
      r_q      <= r_d;
      cd_q     <= cd_d;
      mode_q   <= mode_d;
      done_q   <= done_d;
      preout_q <= preout_d;
    end
  end

  assign busy   = (state_q == ST_ROUND);
  assign done   = done_q;
  assign preout = preout_q;

endmodule

// File: tb/tb_des_round_engine.sv
// Directed bench for des_round_engine: known-answer vectors pushed to a scoreboard
// at acceptance and compared (value and cycle) when done pulses.
module tb_des_round_engine;
  logic        clk = 1'b0;
  logic        rst, start, decrypt;
  logic [63:0] block_in, key;
  logic        busy, done;
  logic [63:0] preout;

  localparam logic [63:0] KEY  = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT   = 64'hCC00CCFFF0AAF0AA;
  localparam logic [63:0] CT   = 64'h0A4CD99543423234;
  localparam logic [63:0] PAR  = 64'h0101010101010101;
  localparam logic [63:0] KEY2 = 64'h123456789ABCDEF0;

  typedef struct {
    logic [63:0] val;
    logic        known;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_pass = 0, n_total = 0, n_fail = 0;
  logic [63:0] y;

  des_round_engine dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .decrypt  (decrypt),
    .block_in (block_in),
    .key      (key),
    .busy     (busy),
    .done     (done),
    .preout   (preout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Scoreboard side: done must fire exactly at the cycle recorded at acceptance.
  always @(negedge clk) begin
    logic exp_done;
    exp_done = (sb.size() != 0) && (sb[0].cyc == cyc);
    chk("done", {63'd0, done}, {63'd0, exp_done});
    if (exp_done) begin
      if (sb[0].known) chk("preout", preout, sb[0].val);
      void'(sb.pop_front());
    end
  end

  task automatic launch(input logic dec, input logic [63:0] blk, input logic [63:0] k,
                        input logic [63:0] expv, input logic known);
    @(negedge clk);
    start = 1'b1; decrypt = dec; block_in = blk; key = k;
    @(posedge clk); #1;
    sb.push_back('{expv, known, cyc + 16});
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    start = 1'b0; decrypt = ~dec;
    block_in = {$urandom, $urandom}; key = {$urandom, $urandom};
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk); n++;
    end
    #1;
    chk("done_timeout", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; decrypt = 1'b0; block_in = '0; key = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_preout", preout, 64'd0);
    rst = 1'b0;

    // Known-answer encrypt and decrypt.
    launch(1'b0, PT, KEY, CT, 1'b1);
    wait_done();
    launch(1'b1, CT, KEY, PT, 1'b1);
    wait_done();

    // start during rnd=5 with a different block must be ignored.
    launch(1'b0, PT, KEY, CT, 1'b1);
    repeat (5) @(posedge clk);
    #1; start = 1'b1; decrypt = 1'b1; block_in = 64'hFFFF0000FFFF0000;
    @(posedge clk); #1; start = 1'b0;
    chk("busy_mid", {63'd0, busy}, 64'd1);
    wait_done();

    // Reset at rnd=8 aborts and clears outputs asynchronously.
    launch(1'b1, CT, KEY, PT, 1'b1);
    repeat (8) @(posedge clk);
    @(negedge clk); #2;
    rst = 1'b1; sb.delete();
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_preout", preout, 64'd0);
    @(negedge clk); rst = 1'b0;
    launch(1'b0, PT, KEY, CT, 1'b1);
    wait_done();

    // Back-to-back with start held: one block per 17 cycles, busy low only in the gap.
    @(negedge clk);
    start = 1'b1; key = KEY;
    for (int k = 0; k < 4; k++) begin
      decrypt  = (k % 2 == 1);
      block_in = (k % 2 == 1) ? CT : PT;
      @(posedge clk); #1;
      sb.push_back('{(k % 2 == 1) ? PT : CT, 1'b1, cyc + 16});
      chk("b2b_busy_start", {63'd0, busy}, 64'd1);
      repeat (15) @(posedge clk);
      #1; chk("b2b_busy_r15", {63'd0, busy}, 64'd1);
      @(posedge clk);
      @(negedge clk);
      chk("b2b_busy_gap", {63'd0, busy}, 64'd0);
    end
    start = 1'b0;
    wait_done();

    // Parity bits of the key are ignored.
    launch(1'b0, PT, KEY ^ PAR, CT, 1'b1);
    wait_done();
    launch(1'b0, PT, KEY2 ^ PAR, 64'd0, 1'b0);
    wait_done();
    y = preout;
    launch(1'b1, y, KEY2, PT, 1'b1);
    wait_done();

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
